// File: rtl/bias_regfile_ctrl.sv
// bias_regfile_ctrl
// Loadable multi-port bias table. A DEPTH x DATA_W table is filled once from a streaming
// load port. Once the table is complete, it serves NPORTS independent lookups per read.
// Read results are registered and come with a 1-cycle bias_valid pulse.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   ld_start            begin/restart a full table load at entry 0
//   ld_valid/ld_data    load word stream; accepted when ld_valid & ld_ready
//   ld_ready            high while loading (and not in an ld_start cycle)
//   ld_done             1-cycle pulse after the last entry is written
//   rd_valid/rd_addr    read request, NPORTS packed lane addresses
//   rd_ready            high while the table is complete
//   bias                registered per-lane bias words (lane i at [i*DATA_W +: DATA_W])
//   bias_valid          1-cycle pulse when bias/rd_err were updated
//   rd_err              registered per-lane flag, address >= DEPTH
//
// Optional feature macro: BIAS_UPDATE_EN
//   Adds upd_valid/upd_addr/upd_data for single-entry writes while ACTIVE. A same-cycle read
//   of the address being written returns the new data (write-first).
module bias_regfile_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NPORTS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
  output logic                     ld_done,
`ifdef BIAS_UPDATE_EN
  input  logic                     upd_valid,
  input  logic [ADDR_W-1:0]        upd_addr,
  input  logic [DATA_W-1:0]        upd_data,
`endif
  input  logic                     rd_valid,
  input  logic [NPORTS*ADDR_W-1:0] rd_addr,
  output logic                     rd_ready,
  output logic [NPORTS*DATA_W-1:0] bias,
  output logic                     bias_valid,
  output logic [NPORTS-1:0]        rd_err
);

  typedef enum logic [1:0] {StEmpty, StLoad, StActive} state_e;

  localparam int unsigned AW1 = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthW   = AW1'(DEPTH);

  // DEPTH need not be a power of two, so lane addresses can exceed the table.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DepthW;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                done_d;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic                rd_fire;
  logic [NPORTS*DATA_W-1:0] rd_word;
  logic [NPORTS-1:0]   rd_oob;

`ifdef BIAS_UPDATE_EN
  logic upd_we;
  assign upd_we = (state_q == StActive) && !ld_start && upd_valid && in_range(upd_addr);
`endif

  assign ld_ready = (state_q == StLoad) && !ld_start;
  assign rd_ready = (state_q == StActive);
  assign rd_fire  = rd_valid && rd_ready;

  // Next-state, load pointer and table write port. Load and update writes are exclusive by
  // state, so a single write port serves both.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = ptr_q;
    wdata   = ld_data;
    case (state_q)
      StEmpty: begin
        if (ld_start) begin
          state_d = StLoad;
          ptr_d   = '0;
        end
      end
      StLoad: begin
        if (ld_start) begin
          // Restart discards the partial load.
          ptr_d = '0;
        end else if (ld_valid) begin
          we = 1'b1;
          if (ptr_q == LastAddr) begin
            ptr_d   = '0;
            state_d = StActive;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      StActive: begin
        if (ld_start) begin
          state_d = StLoad;
          ptr_d   = '0;
        end
`ifdef BIAS_UPDATE_EN
        else if (upd_we) begin
          we    = 1'b1;
          waddr = upd_addr;
          wdata = upd_data;
        end
`endif
      end
      default: begin
        state_d = StEmpty;
        ptr_d   = '0;
      end
    endcase
  end

  // Per-lane lookup; out-of-range lanes read as zero and flag an error.
  always_comb begin
    rd_word = '0;
    rd_oob  = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      logic [ADDR_W-1:0] a;
      a = rd_addr[i*ADDR_W +: ADDR_W];
      if (in_range(a)) begin
        rd_word[i*DATA_W +: DATA_W] = mem[a];
`ifdef BIAS_UPDATE_EN
        if (upd_we && (a == upd_addr)) begin
          rd_word[i*DATA_W +: DATA_W] = upd_data;
        end
`endif
      end else begin
        rd_oob[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      ptr_q      <= '0;
      ld_done    <= 1'b0;
      bias       <= '0;
      bias_valid <= 1'b0;
      rd_err     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ld_done    <= done_d;
      bias_valid <= rd_fire;
      if (rd_fire) begin
        bias   <= rd_word;
        rd_err <= rd_oob;
      end
    end
  end

  // Table storage is not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_bias_regfile_ctrl.sv
// Testbench for bias_regfile_ctrl: a DEPTH=128 instance checked every cycle against a
// table-level model, plus a DEPTH=100 instance for out-of-range lane handling.
module tb_bias_regfile_ctrl;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DEPTH=128 instance
  logic             ld_start, ld_valid, ld_ready, ld_done;
  logic [DW-1:0]    ld_data;
  logic             rd_valid, rd_ready, bias_valid;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] bias;
  logic [NP-1:0]    rd_err;
`ifdef BIAS_UPDATE_EN
  logic             upd_valid;
  logic [AW-1:0]    upd_addr;
  logic [DW-1:0]    upd_data;
`endif

  // DEPTH=100 instance
  logic             b_ld_start, b_ld_valid, b_ld_ready, b_ld_done;
  logic [DW-1:0]    b_ld_data;
  logic             b_rd_valid, b_rd_ready, b_bias_valid;
  logic [NP*AW-1:0] b_rd_addr;
  logic [NP*DW-1:0] b_bias;
  logic [NP-1:0]    b_rd_err;

  bias_regfile_ctrl #(.DATA_W(DW), .DEPTH(128), .ADDR_W(AW), .NPORTS(NP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
`ifdef BIAS_UPDATE_EN
    .upd_valid  (upd_valid),
    .upd_addr   (upd_addr),
    .upd_data   (upd_data),
`endif
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_ready   (rd_ready),
    .bias       (bias),
    .bias_valid (bias_valid),
    .rd_err     (rd_err)
  );

  bias_regfile_ctrl #(.DATA_W(DW), .DEPTH(100), .ADDR_W(AW), .NPORTS(NP)) dut100 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_start   (b_ld_start),
    .ld_valid   (b_ld_valid),
    .ld_data    (b_ld_data),
    .ld_ready   (b_ld_ready),
    .ld_done    (b_ld_done),
`ifdef BIAS_UPDATE_EN
    .upd_valid  (1'b0),
    .upd_addr   ('0),
    .upd_data   ('0),
`endif
    .rd_valid   (b_rd_valid),
    .rd_addr    (b_rd_addr),
    .rd_ready   (b_rd_ready),
    .bias       (b_bias),
    .bias_valid (b_bias_valid),
    .rd_err     (b_rd_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NP*AW-1:0] pack(input int a0, input int a1, input int a2,
                                            input int a3);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of the DEPTH=128 instance: table contents, load progress, expected registered outputs.
  logic [DW-1:0]    m_tab [128];
  int               m_mode = 0;   // 0 empty, 1 loading, 2 complete
  int               m_cnt  = 0;
  logic             m_init = 1'b0;
  logic [NP*DW-1:0] e_bias;
  logic [NP-1:0]    e_err;
  logic             e_bv, e_done;

  always @(negedge clk) begin
    if (m_init) begin
      check("ld_ready", ld_ready, (m_mode == 1) && !ld_start);
      check("rd_ready", rd_ready, m_mode == 2);
      check("ld_done", ld_done, e_done);
      check("bias_valid", bias_valid, e_bv);
      check("bias", bias, e_bias);
      check("rd_err", rd_err, e_err);
    end
    if (!rst_n) begin
      m_init = 1'b1;
      m_mode = 0;
      m_cnt  = 0;
      e_bias = '0;
      e_err  = '0;
      e_bv   = 1'b0;
      e_done = 1'b0;
    end else begin
      e_bv   = 1'b0;
      e_done = 1'b0;
      if (m_mode == 2 && rd_valid) begin
        e_bv = 1'b1;
        for (int i = 0; i < NP; i++) begin
          int a;
          logic [DW-1:0] v;
          a = int'(rd_addr[i*AW +: AW]);
          if (a < 128) begin
            v = m_tab[a];
`ifdef BIAS_UPDATE_EN
            if (!ld_start && upd_valid && int'(upd_addr) == a) v = upd_data;
`endif
            e_err[i] = 1'b0;
          end else begin
            v = '0;
            e_err[i] = 1'b1;
          end
          e_bias[i*DW +: DW] = v;
        end
      end
`ifdef BIAS_UPDATE_EN
      if (m_mode == 2 && !ld_start && upd_valid) m_tab[int'(upd_addr)] = upd_data;
`endif
      if (ld_start) begin
        m_mode = 1;
        m_cnt  = 0;
      end else if (m_mode == 1 && ld_valid) begin
        m_tab[m_cnt] = ld_data;
        m_cnt++;
        if (m_cnt == 128) begin
          m_mode = 2;
          m_cnt  = 0;
          e_done = 1'b1;
        end
      end
    end
  end

  // Event counters for the DEPTH=128 instance.
  int n_ldr = 0;
  int n_done = 0;
  always @(negedge clk) begin
    if (ld_ready) n_ldr++;
    if (ld_done) n_done++;
  end

  initial begin
    rst_n = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; rd_valid = 1'b0; rd_addr = '0;
    b_ld_start = 1'b0; b_ld_valid = 1'b0; b_ld_data = '0; b_rd_valid = 1'b0; b_rd_addr = '0;
`ifdef BIAS_UPDATE_EN
    upd_valid = 1'b0; upd_addr = '0; upd_data = '0;
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // Reads before any load are refused.
    rd_valid = 1'b1;
    rd_addr  = pack(1, 2, 3, 4);
    repeat (3) tick();
    @(negedge clk);
    check("t1_rd_ready", rd_ready, 1'b0);
    check("t1_bias_valid", bias_valid, 1'b0);
    check("t1_bias", bias, '0);
    tick();
    rd_valid = 1'b0;

    // Full load, mem[k] = 3k.
    n_ldr = 0;
    n_done = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int k = 0; k < 128; k++) begin
      ld_valid = 1'b1;
      ld_data  = 32'(k * 3);
      tick();
    end
    ld_valid = 1'b0;
    @(negedge clk);
    check("t2_ld_done", ld_done, 1'b1);
    check("t2_rd_ready", rd_ready, 1'b1);
    tick();
    check("t2_ld_ready_cycles", 32'(n_ldr), 32'd128);
    check("t2_ld_done_count", 32'(n_done), 32'd1);

    // Four-lane read.
    rd_valid = 1'b1;
    rd_addr  = pack(5, 0, 127, 64);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    check("t3_bias", bias, {32'd192, 32'd381, 32'd0, 32'd15});
    check("t3_bias_valid", bias_valid, 1'b1);
    check("t3_rd_err", rd_err, 4'b0000);
    tick();
    @(negedge clk);
    check("t3_valid_pulse", bias_valid, 1'b0);
    check("t3_bias_hold", bias, {32'd192, 32'd381, 32'd0, 32'd15});
    tick();

    // DEPTH=100 instance: lane 0 out of range.
    b_ld_start = 1'b1;
    tick();
    b_ld_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      b_ld_valid = 1'b1;
      b_ld_data  = 32'(k * 3);
      tick();
    end
    b_ld_valid = 1'b0;
    @(negedge clk);
    check("t4_ld_done", b_ld_done, 1'b1);
    tick();
    b_rd_valid = 1'b1;
    b_rd_addr  = pack(110, 5, 99, 0);
    tick();
    b_rd_valid = 1'b0;
    @(negedge clk);
    check("t4_bias", b_bias, {32'd0, 32'd297, 32'd15, 32'd0});
    check("t4_rd_err", b_rd_err, 4'b0001);
    check("t4_bias_valid", b_bias_valid, 1'b1);
    tick();

    // Read in the ld_start cycle sees old contents; partial load then restart.
    ld_start = 1'b1;
    rd_valid = 1'b1;
    rd_addr  = pack(5, 1, 2, 3);
    tick();
    ld_start = 1'b0;
    rd_valid = 1'b0;
    @(negedge clk);
    check("t5_read_at_start", bias, {32'd9, 32'd6, 32'd3, 32'd15});
    check("t5_rd_ready_drop", rd_ready, 1'b0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hA5A5_0000 | 32'(k);
      tick();
    end
    ld_valid = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("t5_no_done_partial", 32'(n_done), 32'd0);
    for (int k = 0; k < 128; k++) begin
      ld_valid = 1'b1;
      ld_data  = ~32'(k);
      tick();
    end
    ld_valid = 1'b0;
    tick();
    check("t5_done_count", 32'(n_done), 32'd1);
    rd_valid = 1'b1;
    rd_addr  = pack(3, 127, 0, 40);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    check("t5_reload_bias", bias, {~32'd40, ~32'd0, ~32'd127, ~32'd3});
    tick();

`ifdef BIAS_UPDATE_EN
    // Update with same-cycle read forwarding, then a later read.
    upd_valid = 1'b1;
    upd_addr  = 7'd7;
    upd_data  = 32'hDEAD;
    rd_valid  = 1'b1;
    rd_addr   = pack(0, 7, 1, 2);
    tick();
    upd_valid = 1'b0;
    rd_valid  = 1'b0;
    @(negedge clk);
    check("t6_forward", bias, {~32'd2, ~32'd1, 32'hDEAD, ~32'd0});
    tick();
    rd_valid = 1'b1;
    rd_addr  = pack(7, 7, 7, 7);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    check("t6_stored", bias, {4{32'hDEAD}});
    tick();
`endif

    // Reset in the middle of a load: table stays unusable until a fresh load.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ld_valid = 1'b1;
      ld_data  = 32'(k);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd_valid = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("t7_rd_ready", rd_ready, 1'b0);
    check("t7_ld_ready", ld_ready, 1'b0);
    check("t7_bias_valid", bias_valid, 1'b0);
    tick();
    ld_valid = 1'b0;
    rd_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
